// File: rtl/rvfpm_result_checker_if.sv
// Handshake/result bundle between the rvfpm DUT environment and the result checker.
// master: the side that drives the DUT stimulus and observes check results.
// slave:  the checker itself.
interface rvfpm_result_checker_if #(
  parameter int XLEN            = 32,
  parameter int PIPELINE_STAGES = 4,
  parameter int CNT_W           = 16
);
  localparam int IFW = $clog2(PIPELINE_STAGES + 1);

  logic            enable;
  logic            clear;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rs2_bits;
  logic [XLEN-1:0] data_toXReg;
  logic [XLEN-1:0] data_toMem;

  logic             chk_valid;
  logic             chk_fail;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [IFW-1:0]   in_flight;
  logic             first_fail_valid;
  logic [31:0]      first_fail_instr;
  logic [31:0]      first_fail_cycle;

  modport master (
    output enable, clear, instruction, rs2_bits, data_toXReg, data_toMem,
    input  chk_valid, chk_fail, err_cnt, pass_cnt, in_flight,
           first_fail_valid, first_fail_instr, first_fail_cycle
  );

  modport slave (
    input  enable, clear, instruction, rs2_bits, data_toXReg, data_toMem,
    output chk_valid, chk_fail, err_cnt, pass_cnt, in_flight,
           first_fail_valid, first_fail_instr, first_fail_cycle
  );
endinterface

// File: rtl/rvfpm_result_checker.sv
// Result checker for FSW / FMV.X.W through the rvfpm pipeline.
// A stall-aware shadow pipeline records what each tracked instruction must
// produce; the retiring entry is compared against the DUT result on the same
// enabled edge that it leaves the pipeline.
// Optional feature macro: RVFPM_CHK_FIRSTFAIL_EN (first-failure capture).
module rvfpm_result_checker #(
  parameter int XLEN            = 32,
  parameter int PIPELINE_STAGES = 4,
  parameter int CNT_W           = 16
) (
  input logic                   ck,
  input logic                   rst,
  rvfpm_result_checker_if.slave bus
);
  localparam int P   = PIPELINE_STAGES;
  localparam int IFW = $clog2(P + 1);

  // Shadow pipeline: kind bit is 1 for store data, 0 for integer-register result.
  logic [P-1:0]    pipe_valid;
  logic [P-1:0]    pipe_mem;
  logic [XLEN-1:0] pipe_exp [P];
`ifdef RVFPM_CHK_FIRSTFAIL_EN
  logic [31:0]     pipe_instr [P];
  logic            ff_valid_q;
  logic [31:0]     ff_instr_q;
  logic [31:0]     ff_cycle_q;
`endif

  logic            is_fsw;
  logic            is_fmv;
  logic            issue_valid;
  logic            retire_valid;
  logic            retire_mismatch;
  logic [XLEN-1:0] retire_data;
  logic            chk_valid_q;
  logic            chk_fail_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] pass_q;
  logic [31:0]     cycle_q;
  logic [IFW-1:0]  in_flight_c;

  // Issue decode: only FSW and FMV.X.W are tracked, everything else is a bubble.
  always_comb begin
    is_fsw      = (bus.instruction[6:0] == 7'b0100111) &&
                  (bus.instruction[14:12] == 3'b010);
    is_fmv      = (bus.instruction[6:0] == 7'b1010011) &&
                  (bus.instruction[31:25] == 7'b1110000) &&
                  (bus.instruction[14:12] == 3'b000) &&
                  (bus.instruction[24:20] == 5'b00000);
    issue_valid = is_fsw || is_fmv;
  end

  // Retire compare: a check exists only when the pipeline actually advances.
  always_comb begin
    retire_valid    = bus.enable && pipe_valid[P-1];
    retire_data     = pipe_mem[P-1] ? bus.data_toMem : bus.data_toXReg;
    retire_mismatch = retire_valid && (retire_data != pipe_exp[P-1]);
  end

  // Occupancy is the population count of the valid bits.
  always_comb begin
    in_flight_c = '0;
    for (int i = 0; i < P; i++) begin
      in_flight_c = in_flight_c + IFW'(pipe_valid[i]);
    end
  end

  // Shadow pipeline advance; holds every entry while enable is low.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_mem   <= '0;
      for (int i = 0; i < P; i++) begin
        pipe_exp[i] <= '0;
      end
    end else if (bus.clear) begin
      pipe_valid <= '0;
    end else if (bus.enable) begin
      for (int k = P - 1; k > 0; k--) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_mem[k]   <= pipe_mem[k-1];
        pipe_exp[k]   <= pipe_exp[k-1];
      end
      pipe_valid[0] <= issue_valid;
      pipe_mem[0]   <= is_fsw;
      pipe_exp[0]   <= bus.rs2_bits;
    end
  end

  // Check pulse and saturating pass/error counters.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      chk_valid_q <= 1'b0;
      chk_fail_q  <= 1'b0;
      err_q       <= '0;
      pass_q      <= '0;
    end else if (bus.clear) begin
      chk_valid_q <= 1'b0;
      chk_fail_q  <= 1'b0;
      err_q       <= '0;
      pass_q      <= '0;
    end else begin
      chk_valid_q <= retire_valid;
      chk_fail_q  <= retire_mismatch;
      if (retire_mismatch && (err_q != '1)) begin
        err_q <= err_q + CNT_W'(1);
      end
      if (retire_valid && !retire_mismatch && (pass_q != '1)) begin
        pass_q <= pass_q + CNT_W'(1);
      end
    end
  end

  // Free-running cycle stamp; deliberately not affected by clear.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

`ifdef RVFPM_CHK_FIRSTFAIL_EN
  // Instruction words ride alongside the shadow entries for the failure record.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < P; i++) begin
        pipe_instr[i] <= '0;
      end
    end else if (bus.enable && !bus.clear) begin
      for (int k = P - 1; k > 0; k--) begin
        pipe_instr[k] <= pipe_instr[k-1];
      end
      pipe_instr[0] <= bus.instruction;
    end
  end

  // Latch the first mismatch only; the stamp is the cycle count at the failing edge.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ff_valid_q <= 1'b0;
      ff_instr_q <= '0;
      ff_cycle_q <= '0;
    end else if (bus.clear) begin
      ff_valid_q <= 1'b0;
      ff_instr_q <= '0;
      ff_cycle_q <= '0;
    end else if (retire_mismatch && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_instr_q <= pipe_instr[P-1];
      ff_cycle_q <= cycle_q;
    end
  end

  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_instr = ff_instr_q;
  assign bus.first_fail_cycle = ff_cycle_q;
`else
  assign bus.first_fail_valid = 1'b0;
  assign bus.first_fail_instr = '0;
  assign bus.first_fail_cycle = '0;
`endif

  assign bus.chk_valid = chk_valid_q;
  assign bus.chk_fail  = chk_fail_q;
  assign bus.err_cnt   = err_q;
  assign bus.pass_cnt  = pass_q;
  assign bus.in_flight = in_flight_c;
endmodule

// File: tb/tb_rvfpm_result_checker.sv
// Self-checking bench for rvfpm_result_checker: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_rvfpm_result_checker;
  localparam int P    = 4;
  localparam int XLEN = 32;
`ifdef RVFPM_CHK_FIRSTFAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  localparam logic [31:0] FSW_A   = 32'h00552027; // fsw f5,0(x10)
  localparam logic [31:0] FMV_A   = 32'hE00305D3; // fmv.x.w x11,f6
  localparam logic [31:0] FMV_B   = 32'hE0030653; // fmv.x.w x12,f6
  localparam logic [31:0] ADDS    = 32'h003100D3; // fadd.s f1,f2,f3
  localparam logic [31:0] FSD     = 32'h00553027; // funct3 011: not tracked
  localparam logic [31:0] FMV_RS2 = 32'hE01305D3; // rs2 field nonzero: not tracked
  localparam logic [31:0] NOP     = 32'h00000013;

  logic ck = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] rs2_bits = '0;
  logic [31:0] data_toXReg = '0;
  logic [31:0] data_toMem = '0;

  always #5 ck = ~ck;

  rvfpm_result_checker_if #(.XLEN(XLEN), .PIPELINE_STAGES(P), .CNT_W(16)) bif ();
  rvfpm_result_checker_if #(.XLEN(XLEN), .PIPELINE_STAGES(P), .CNT_W(2))  sif ();

  assign bif.enable      = enable;
  assign bif.clear       = clear;
  assign bif.instruction = instruction;
  assign bif.rs2_bits    = rs2_bits;
  assign bif.data_toXReg = data_toXReg;
  assign bif.data_toMem  = data_toMem;
  assign sif.enable      = enable;
  assign sif.clear       = clear;
  assign sif.instruction = instruction;
  assign sif.rs2_bits    = rs2_bits;
  assign sif.data_toXReg = data_toXReg;
  assign sif.data_toMem  = data_toMem;

  rvfpm_result_checker #(.XLEN(XLEN), .PIPELINE_STAGES(P), .CNT_W(16)) dut (
    .ck(ck), .rst(rst), .bus(bif));
  rvfpm_result_checker #(.XLEN(XLEN), .PIPELINE_STAGES(P), .CNT_W(2)) dut_sat (
    .ck(ck), .rst(rst), .bus(sif));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    bit          mem;
    logic [31:0] exp;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  int          m_err = 0;
  int          m_pass = 0;
  bit          m_cv = 0;
  bit          m_cf = 0;
  bit          m_ffv = 0;
  logic [31:0] m_ffi = '0;
  logic [31:0] m_ffc = '0;
  logic [31:0] m_cycle = '0;

  function automatic entry_t decode(input logic [31:0] w, input logic [31:0] r2);
    entry_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs2f;
    opc  = w[6:0];
    f3   = w[14:12];
    f7   = w[31:25];
    rs2f = w[24:20];
    e.mem   = (opc == 7'h27) && (f3 == 3'd2);
    e.valid = e.mem || ((opc == 7'h53) && (f7 == 7'h70) && (f3 == 3'd0) && (rs2f == 5'd0));
    e.exp   = r2;
    e.instr = w;
    return e;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int valid_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].valid) n++;
    return n;
  endfunction

  task automatic model_step();
    entry_t e;
    bit bad;
    m_cv = 0;
    m_cf = 0;
    if (clear) begin
      mq.delete();
      m_err = 0;
      m_pass = 0;
      m_ffv = 0;
      m_ffi = '0;
      m_ffc = '0;
    end else if (enable) begin
      mq.push_back(decode(instruction, rs2_bits));
      if (mq.size() > P) begin
        e = mq.pop_front();
        if (e.valid) begin
          bad  = e.mem ? (data_toMem != e.exp) : (data_toXReg != e.exp);
          m_cv = 1;
          m_cf = bad;
          if (bad) begin
            m_err++;
            if (!m_ffv) begin
              m_ffv = 1;
              m_ffi = e.instr;
              m_ffc = m_cycle;
            end
          end else begin
            m_pass++;
          end
        end
      end
    end
    m_cycle = m_cycle + 32'd1;
  endtask

  // Asynchronous reset wipes the model just as it wipes the DUT.
  always @(negedge rst) begin
    mq.delete();
    m_err = 0; m_pass = 0; m_cv = 0; m_cf = 0;
    m_ffv = 0; m_ffi = '0; m_ffc = '0; m_cycle = '0;
  end

  // Compare process: advance the model on each edge, check outputs 1 time unit later.
  always @(posedge ck) begin
    if (rst) model_step();
    #1;
    chk("chk_valid", bif.chk_valid, m_cv);
    chk("chk_fail", bif.chk_fail, m_cf);
    chk("err_cnt", bif.err_cnt, sat(m_err, 65535));
    chk("pass_cnt", bif.pass_cnt, sat(m_pass, 65535));
    chk("in_flight", bif.in_flight, valid_count());
    chk("ff_valid", bif.first_fail_valid, FF_EN ? m_ffv : 1'b0);
    chk("ff_instr", bif.first_fail_instr, FF_EN ? m_ffi : 32'h0);
    chk("ff_cycle", bif.first_fail_cycle, FF_EN ? m_ffc : 32'h0);
    chk("sat_err_cnt", sif.err_cnt, sat(m_err, 3));
    chk("sat_pass_cnt", sif.pass_cnt, sat(m_pass, 3));
  end

  // ---------------- stimulus ----------------
  int pulses = 0;
  int peak = 0;

  task automatic cyc(input bit en, input bit clr, input logic [31:0] ins,
                     input logic [31:0] r2, input logic [31:0] xr, input logic [31:0] mem);
    enable      = en;
    clear       = clr;
    instruction = ins;
    rs2_bits    = r2;
    data_toXReg = xr;
    data_toMem  = mem;
    @(negedge ck);
    if (bif.chk_valid) pulses++;
    if (int'(bif.in_flight) > peak) peak = int'(bif.in_flight);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge ck);
    chk("rst_in_flight", bif.in_flight, 0);
    chk("rst_chk_valid", bif.chk_valid, 0);
    rst = 1'b1;

    // 1: FSW, enable held, match at 4th edge
    pulses = 0;
    cyc(1, 0, FSW_A, 32'h3F800000, 0, 32'h3F800000);
    repeat (4) cyc(1, 0, NOP, 0, 0, 32'h3F800000);
    chk("t1_pulses", pulses, 1);
    chk("t1_chk_valid", bif.chk_valid, 1);
    chk("t1_chk_fail", bif.chk_fail, 0);
    chk("t1_pass_cnt", bif.pass_cnt, 1);

    // 2: FMV.X.W with a 3-cycle stall, mismatch after 7 total edges
    pulses = 0;
    cyc(1, 0, FMV_A, 32'hDEADBEEE, 32'hDEADBEEF, 0);
    cyc(1, 0, NOP, 0, 32'hDEADBEEF, 0);
    repeat (3) cyc(0, 0, NOP, 0, 32'hDEADBEEF, 0);
    repeat (2) cyc(1, 0, NOP, 0, 32'hDEADBEEF, 0);
    chk("t2_no_early_check", pulses, 0);
    cyc(1, 0, NOP, 0, 32'hDEADBEEF, 0);
    chk("t2_pulses", pulses, 1);
    chk("t2_chk_fail", bif.chk_fail, 1);
    chk("t2_err_cnt", bif.err_cnt, 1);
    chk("t2_ff_instr", bif.first_fail_instr, FF_EN ? FMV_A : 32'h0);

    // 3: back-to-back FSW, FMV.X.W, fadd.s, FSW
    pulses = 0;
    peak = 0;
    cyc(1, 0, FSW_A, 32'h11111111, 0, 0);
    cyc(1, 0, FMV_B, 32'h22222222, 0, 0);
    cyc(1, 0, ADDS,  32'h33333333, 0, 0);
    cyc(1, 0, FSW_A, 32'h44444444, 0, 0);
    cyc(1, 0, NOP, 0, 0, 32'h11111111);
    cyc(1, 0, NOP, 0, 32'h22222223, 0);
    cyc(1, 0, NOP, 0, 0, 0);
    cyc(1, 0, NOP, 0, 0, 32'h44444444);
    cyc(1, 0, NOP, 0, 0, 0);
    chk("t3_pulses", pulses, 3);
    chk("t3_peak", peak, 3);
    chk("t3_pass_cnt", bif.pass_cnt, 3);
    chk("t3_err_cnt", bif.err_cnt, 2);
    chk("t3_ff_kept", bif.first_fail_instr, FF_EN ? FMV_A : 32'h0);
    chk("t3_in_flight", bif.in_flight, 0);

    // 4: reset with two entries in flight
    cyc(1, 0, FSW_A, 32'h5, 0, 0);
    cyc(1, 0, FMV_B, 32'h6, 0, 0);
    chk("t4_in_flight", bif.in_flight, 2);
    rst = 1'b0;
    #1;
    chk("t4_rst_in_flight", bif.in_flight, 0);
    chk("t4_rst_err", bif.err_cnt, 0);
    chk("t4_rst_pass", bif.pass_cnt, 0);
    chk("t4_rst_ffv", bif.first_fail_valid, 0);
    @(negedge ck);
    rst = 1'b1;
    pulses = 0;
    repeat (6) cyc(1, 0, NOP, 0, 0, 0);
    chk("t4_no_check", pulses, 0);

    // 5: five failures, 2-bit counter saturates at 3
    pulses = 0;
    repeat (5) cyc(1, 0, FMV_B, 32'h1, 32'h2, 0);
    repeat (4) cyc(1, 0, NOP, 0, 32'h2, 0);
    chk("t5_pulses", pulses, 5);
    chk("t5_err_cnt", bif.err_cnt, 5);
    chk("t5_sat_err", sif.err_cnt, 3);
    chk("t5_ff_instr", bif.first_fail_instr, FF_EN ? FMV_B : 32'h0);

    // 6: clear on the same edge as a valid retire
    cyc(1, 0, FSW_A, 32'h5, 0, 32'h5);
    repeat (3) cyc(1, 0, NOP, 0, 0, 32'h5);
    pulses = 0;
    cyc(1, 1, NOP, 0, 0, 32'h5);
    chk("t6_chk_valid", bif.chk_valid, 0);
    chk("t6_err", bif.err_cnt, 0);
    chk("t6_pass", bif.pass_cnt, 0);
    chk("t6_in_flight", bif.in_flight, 0);
    chk("t6_sat_err", sif.err_cnt, 0);
    repeat (5) cyc(1, 0, NOP, 0, 0, 32'h5);
    chk("t6_pulses", pulses, 0);

    // 7: near-miss encodings are bubbles
    pulses = 0;
    cyc(1, 0, FSD, 32'h7, 0, 0);
    cyc(1, 0, FMV_RS2, 32'h7, 0, 0);
    chk("t7_in_flight", bif.in_flight, 0);
    repeat (4) cyc(1, 0, NOP, 0, 0, 0);
    chk("t7_pulses", pulses, 0);

    repeat (2) cyc(0, 0, NOP, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
